// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the iterative AES inverse-cipher round sequencer.
// Byte i of a block is bits [127-8*i -: 8]; word c holds bytes 4c..4c+3, i.e. column c.
package aes_dec_pkg;

  localparam int BLOCK_W    = 128;
  localparam int NR_DEFAULT = 10;
  localparam int KIDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

  function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk, input int idx);
    return blk[BLOCK_W-1-8*idx -: 8];
  endfunction

  function automatic logic [31:0] get_word(input logic [BLOCK_W-1:0] blk, input int idx);
    return blk[BLOCK_W-1-32*idx -: 32];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last=1).
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] rk,
  input  logic               last,
  output logic [BLOCK_W-1:0] result
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse S-box computed rather than tabulated: undo the affine map, then
  // take the GF(2^8) inverse as x^254 (which maps 0 to 0 as required).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] p;
    logic [7:0] r;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    p = t;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [BLOCK_W-1:0] ark;

  genvar gi;

  // Row r is rotated right by r, so output (row, col) reads input (row, col-row).
  for (gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign ark[BLOCK_W-1-8*gi -: 8] = inv_sbox(get_byte(state, SRC)) ^ get_byte(rk, gi);
  end

  for (gi = 0; gi < 4; gi++) begin : g_col
    assign result[BLOCK_W-1-32*gi -: 32] =
        last ? get_word(ark, gi) : inv_mix_col(get_word(ark, gi));
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: initial AddRoundKey on accept, NR-1 full
// inverse rounds, one final round, then holds the plaintext until taken.
// Optional macro AES_DEC_FLUSH_EN adds a flush input that discards the in-flight block.
module aes_inv_round_ctrl
  import aes_dec_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
`ifdef AES_DEC_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic [KIDX_W-1:0]  key_idx,
  input  logic [BLOCK_W-1:0] key_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
    $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
  end

  localparam logic [KIDX_W-1:0] NR_K    = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] NR_M1_K = KIDX_W'(NR - 1);

  fsm_state_t         fsm_reg;
  logic [KIDX_W-1:0]  rnd_reg;
  logic [BLOCK_W-1:0] blk_reg;
  logic [BLOCK_W-1:0] out_data_reg;
  logic               out_valid_reg;
  logic [BLOCK_W-1:0] round_out;

  aes_inv_round u_round (
    .state  (blk_reg),
    .rk     (key_in),
    .last   (fsm_reg == FINAL),
    .result (round_out)
  );

  assign in_ready  = (fsm_reg == IDLE) && !rst;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // Round-key index: rk[NR] for the initial AddRoundKey, the counter while iterating, rk[0] last.
  always_comb begin
    key_idx = '0;
    case (fsm_reg)
      IDLE:    key_idx = NR_K;
      ROUND:   key_idx = rnd_reg;
      default: key_idx = '0;
    endcase
  end

  // Sequencer: state register, round counter and registered output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= IDLE;
      rnd_reg       <= NR_K;
      blk_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
`ifdef AES_DEC_FLUSH_EN
    end else if (flush && fsm_reg != IDLE) begin
      fsm_reg       <= IDLE;
      rnd_reg       <= NR_K;
      out_valid_reg <= 1'b0;
`endif
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (in_valid) begin
            blk_reg <= in_data ^ key_in;
            rnd_reg <= NR_M1_K;
            fsm_reg <= ROUND;
          end
        end
        ROUND: begin
          blk_reg <= round_out;
          rnd_reg <= rnd_reg - 4'd1;
          if (rnd_reg == 4'd1) fsm_reg <= FINAL;
        end
        FINAL: begin
          blk_reg       <= round_out;
          out_data_reg  <= round_out;
          out_valid_reg <= 1'b1;
          fsm_reg       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            fsm_reg       <= IDLE;
          end
        end
        default: fsm_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl using FIPS-197 vectors; the key store is
// expanded here from the cipher key. Define AES_DEC_FLUSH_EN to exercise flush.
module tb_aes_inv_round_ctrl;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   key_idx;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES_DEC_FLUSH_EN
  logic         flush;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  logic [127:0] rk_b [16];
  logic [127:0] rk_c [16];
  logic         key_sel;
  logic [127:0] last_pt;

  assign key_in = key_sel ? rk_c[key_idx] : rk_b[key_idx];

  aes_inv_round_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef AES_DEC_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_idx   (key_idx),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- key store model (forward S-box + AES-128 expansion) ----------------
  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] p = x;
    logic [7:0] v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = tb_mul(p, p);
      v = tb_mul(v, p);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key, input bit sel);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= 10) begin
        if (sel) rk_c[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        else     rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end else begin
        if (sel) rk_c[r] = '0;
        else     rk_b[r] = '0;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One block through accept, rounds, optional stall with ignored in_valid pokes, handshake.
  task automatic run_block(input logic [127:0] ct, input bit sel, input logic [127:0] pt,
                           input int stall, input bit poke);
    int lat = 0;
    int kbad = 0;
    int busy_bad = 0;
    key_sel = sel;
    in_data = ct;
    out_ready = 1'b0;
    check("idle_in_ready", 128'(in_ready), 128'd1);
    check("idle_key_idx", 128'(key_idx), 128'd10);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data = ~ct;
    while (!out_valid && lat < 40) begin
      if (key_idx !== ((lat <= 8) ? 4'(9 - lat) : 4'd0)) kbad++;
      if (in_ready !== 1'b0) busy_bad++;
      tick();
      lat++;
    end
    check("latency", 128'(lat), 128'd10);
    check("key_idx_seq", 128'(kbad), 128'd0);
    check("busy_in_ready", 128'(busy_bad), 128'd0);
    check("out_data", out_data, pt);
    for (int s = 0; s < stall; s++) begin
      in_valid = poke && (s % 2 == 0);
      in_data = {4{$urandom}};
      tick();
      check("stall_out_valid", 128'(out_valid), 128'd1);
      check("stall_out_data", out_data, pt);
      check("stall_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_out_valid", 128'(out_valid), 128'd0);
    check("post_hs_in_ready", 128'(in_ready), 128'd1);
    check("post_hs_out_data", out_data, pt);
    $display("block ct=%h -> pt=%h latency=%0d stall=%0d", ct, out_data, lat, stall);
    last_pt = pt;
  endtask

  typedef struct {
    logic [127:0] ct;
    bit           sel;
    logic [127:0] pt;
    int           stall;
    bit           poke;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int acc_t [2];
    logic [127:0] got [2];
    int n_acc;
    int n_out;
    bit acc;
    bit ovh;
    logic [127:0] od;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    key_sel = 1'b0;
    last_pt = '0;
`ifdef AES_DEC_FLUSH_EN
    flush = 1'b0;
`endif
    expand(KEY_B, 1'b0);
    expand(KEY_C, 1'b1);

    vecs[0] = '{ct: CT_B, sel: 1'b0, pt: PT_B, stall: 0,  poke: 1'b0};
    vecs[1] = '{ct: CT_C, sel: 1'b1, pt: PT_C, stall: 0,  poke: 1'b0};
    vecs[2] = '{ct: CT_B, sel: 1'b0, pt: PT_B, stall: 20, poke: 1'b1};
    vecs[3] = '{ct: CT_C, sel: 1'b1, pt: PT_C, stall: 3,  poke: 1'b1};

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_key_idx", 128'(key_idx), 128'd10);
    rst = 1'b0;
    tick();
    check("rst_release_in_ready", 128'(in_ready), 128'd1);
    $display("reset state checked");

    for (int i = 0; i < 4; i++) begin
      run_block(vecs[i].ct, vecs[i].sel, vecs[i].pt, vecs[i].stall, vecs[i].poke);
    end

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    key_sel = 1'b0;
    in_data = CT_B;
    in_valid = 1'b1;
    n_acc = 0;
    n_out = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    got[0] = '0;
    got[1] = '0;
    for (int cyc = 0; cyc < 60 && n_out < 2; cyc++) begin
      acc = in_valid && in_ready;
      ovh = out_valid && out_ready;
      od = out_data;
      tick();
      if (acc) begin
        if (n_acc < 2) acc_t[n_acc] = cyc;
        n_acc++;
      end
      if (ovh) begin
        got[n_out] = od;
        n_out++;
        if (n_out == 1) begin
          key_sel = 1'b1;
          in_data = CT_C;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", 128'(n_acc), 128'd2);
    check("b2b_interval", 128'(acc_t[1] - acc_t[0]), 128'd12);
    check("b2b_pt0", got[0], PT_B);
    check("b2b_pt1", got[1], PT_C);
    $display("back-to-back: accepts=%0d interval=%0d pt0=%h pt1=%h",
             n_acc, acc_t[1] - acc_t[0], got[0], got[1]);
    last_pt = PT_C;
    tick();

    // Reset in the middle of round 5
    key_sel = 1'b0;
    in_data = CT_B;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready_low", 128'(in_ready), 128'd0);
    tick();
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_out_data", out_data, 128'd0);
    check("midrst_key_idx", 128'(key_idx), 128'd10);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    $display("reset mid-operation checked");
    tick();
    run_block(CT_B, 1'b0, PT_B, 2, 1'b0);

`ifdef AES_DEC_FLUSH_EN
    // Flush in IDLE is a no-op
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle_in_ready", 128'(in_ready), 128'd1);
    check("flush_idle_key_idx", 128'(key_idx), 128'd10);

    // Flush at round 3
    key_sel = 1'b1;
    in_data = CT_C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_rnd_in_ready", 128'(in_ready), 128'd1);
    check("flush_rnd_out_valid", 128'(out_valid), 128'd0);
    check("flush_rnd_out_data", out_data, last_pt);
    begin
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (out_valid) seen++;
      end
      check("flush_rnd_no_output", 128'(seen), 128'd0);
    end
    $display("flush at round 3 checked");

    // Flush while holding the result in DONE
    key_sel = 1'b1;
    in_data = CT_C;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    begin
      int w = 0;
      while (!out_valid && w < 40) begin
        tick();
        w++;
      end
      check("flush_done_reached", 128'(w), 128'd10);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_done_out_valid", 128'(out_valid), 128'd0);
    check("flush_done_in_ready", 128'(in_ready), 128'd1);
    check("flush_done_out_data", out_data, PT_C);
    $display("flush during DONE checked");
    run_block(CT_B, 1'b0, PT_B, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
